// File: rtl/counter_pwm_pkg.sv
// Shared types and constants for the up/down counter + PWM sequencer.
package counter_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } seq_state_t;

  localparam logic SEQ_DIR_UP = 1'b1;
  localparam logic SEQ_DIR_DN = 1'b0;

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// Sequencer bus: configuration/command inputs, counter feedback and counter/PWM drive outputs.
interface pwm_seq_ctrl_if #(
  parameter int unsigned W = 8
);

  logic         start;
  logic         stop;
  logic [W-1:0] per_cfg;
  logic [W-1:0] thr_cfg;
  logic [W-1:0] step;
  logic [W-1:0] cnt;
  logic         en;
  logic         updn;
  logic [W-1:0] per;
  logic [W-1:0] thr;
  logic         busy;
  logic         ramp_done;
  logic         period_tick;
  logic         cfg_err;

  modport master (
    output start, stop, per_cfg, thr_cfg, step, cnt,
    input  en, updn, per, thr, busy, ramp_done, period_tick, cfg_err
  );

  modport slave (
    input  start, stop, per_cfg, thr_cfg, step, cnt,
    output en, updn, per, thr, busy, ramp_done, period_tick, cfg_err
  );

endinterface

// File: rtl/pwm_ramp_step.sv
// Next threshold: min(thr + step, tgt), summed at W+1 bits so it cannot wrap.
module pwm_ramp_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] thr_i,
  input  logic [W-1:0] step_i,
  input  logic [W-1:0] tgt_i,
  output logic [W-1:0] thr_o
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, thr_i} + {1'b0, step_i};
    // A target below the current threshold also lands here, snapping thr down at once.
    if (sum > {1'b0, tgt_i}) thr_o = tgt_i;
    else                     thr_o = sum[W-1:0];
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Center-aligned PWM sequencer: drives counter en/updn, shadows per/thr at period boundaries.
// Optional soft-start ramp enabled by defining PWM_SEQ_RAMP_EN.
module pwm_seq_ctrl
  import counter_pwm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_seq_ctrl_if.slave bus
);

`ifdef PWM_SEQ_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  seq_state_t   state_q, state_d;
  logic         en_q, en_d;
  logic         updn_q, updn_d;
  logic         busy_q, busy_d;
  logic         rdone_q, rdone_d;
  logic         tick_q, tick_d;
  logic         cerr_q, cerr_d;
  logic         first_q, first_d;
  logic [W-1:0] per_q, per_d;
  logic [W-1:0] thr_q, thr_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] per_eff;
  logic [W-1:0] step_eff;
  logic [W-1:0] ramp_thr;
  logic         boundary;
  logic         turn_up;
  logic         start_ok;

  // An all-ones step saturates straight to the target, i.e. no ramp.
  assign step_eff = RAMP_EN ? bus.step : '1;

  pwm_ramp_step #(.W(W)) u_ramp (
    .thr_i  (thr_q),
    .step_i (step_eff),
    .tgt_i  (bus.thr_cfg),
    .thr_o  (ramp_thr)
  );

  always_comb begin
    start_ok = bus.start && (bus.per_cfg != '0);
    boundary = (state_q != IDLE) && en_q && (updn_q == SEQ_DIR_UP) &&
               (bus.cnt == '0) && !first_q;
    turn_up  = en_q && (updn_q == SEQ_DIR_DN) && (bus.cnt == W'(1));
    // The period loaded at a boundary must already govern that cycle's peak check (per==1).
    per_eff  = (boundary && (bus.per_cfg != '0)) ? bus.per_cfg : per_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      updn_q  <= SEQ_DIR_UP;
      busy_q  <= 1'b0;
      rdone_q <= 1'b0;
      tick_q  <= 1'b0;
      cerr_q  <= 1'b0;
      first_q <= 1'b0;
      per_q   <= '0;
      thr_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      updn_q  <= updn_d;
      busy_q  <= busy_d;
      rdone_q <= rdone_d;
      tick_q  <= tick_d;
      cerr_q  <= cerr_d;
      first_q <= first_d;
      per_q   <= per_d;
      thr_q   <= thr_d;
      tgt_q   <= tgt_d;
    end
  end

  // Stopping commits on the last down-step (cnt==1) so the counter halts exactly at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = RUN;
      RUN:      if (bus.stop) state_d = turn_up ? IDLE : STOPPING;
      STOPPING: if (turn_up)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    updn_d  = updn_q;
    per_d   = per_q;
    thr_d   = thr_q;
    tgt_d   = tgt_q;
    tick_d  = 1'b0;
    cerr_d  = 1'b0;
    first_d = 1'b0;

    if (state_q == IDLE) begin
      en_d   = 1'b0;
      updn_d = SEQ_DIR_UP;
      if (start_ok) begin
        per_d   = bus.per_cfg;
        tgt_d   = bus.thr_cfg;
        thr_d   = RAMP_EN ? '0 : bus.thr_cfg;
        en_d    = 1'b1;
        first_d = 1'b1;
      end else if (bus.start) begin
        cerr_d = 1'b1;
      end
    end else begin
      if (en_q && (updn_q == SEQ_DIR_UP) && (bus.cnt == per_eff - W'(1)))
        updn_d = SEQ_DIR_DN;
      else if (turn_up)
        updn_d = SEQ_DIR_UP;

      if (boundary) begin
        tick_d = 1'b1;
        per_d  = per_eff;
        tgt_d  = bus.thr_cfg;
        thr_d  = ramp_thr;
      end

      if (state_d == IDLE) begin
        en_d   = 1'b0;
        thr_d  = '0;
        updn_d = SEQ_DIR_UP;
      end
    end

    busy_d  = (state_d != IDLE);
    rdone_d = (RAMP_EN ? (state_d == RUN) : busy_d) && (thr_d == tgt_d);
  end

  assign bus.en          = en_q;
  assign bus.updn        = updn_q;
  assign bus.per         = per_q;
  assign bus.thr         = thr_q;
  assign bus.busy        = busy_q;
  assign bus.ramp_done   = rdone_q;
  assign bus.period_tick = tick_q;
  assign bus.cfg_err     = cerr_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Closed-loop bench: sequencer driving a behavioural up/down counter, directed vectors.
module tb_pwm_seq_ctrl;

`ifdef PWM_SEQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  pwm_seq_ctrl_if #(.W(8)) bus ();

  pwm_seq_ctrl #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter shares the sequencer's reset domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus.cnt <= '0;
    else if (bus.en) bus.cnt <= bus.updn ? bus.cnt + 8'd1 : bus.cnt - 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_tick(output int cyc, output int pk);
    cyc = 0;
    pk  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (int'(bus.cnt) > pk) pk = int'(bus.cnt);
    end while (!bus.period_tick && cyc < 200);
    chk("tick_seen", bus.period_tick, 1);
  endtask

  task automatic wait_cnt(input logic [7:0] val, input logic dir, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.cnt == val && bus.updn == dir) && n < 100);
    chk(tag, (bus.cnt == val && bus.updn == dir), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 100);
    chk("idle_reached", bus.busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},   bus.en, 0);
    chk({tag, "_updn"}, bus.updn, 1);
    chk({tag, "_per"},  bus.per, 0);
    chk({tag, "_thr"},  bus.thr, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rd"},   bus.ramp_done, 0);
    chk({tag, "_tick"}, bus.period_tick, 0);
    chk({tag, "_cerr"}, bus.cfg_err, 0);
    chk({tag, "_cnt"},  bus.cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, pk, m;
    int exp_thr2 [4];
    exp_thr2 = RAMP ? '{3, 6, 7, 7} : '{7, 7, 7, 7};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.per_cfg = '0;
    bus.thr_cfg = '0;
    bus.step    = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);

    // per=4, thr=2, step=2: triangle 0..4..0, tick every 8 cycles
    bus.per_cfg = 8'd4;
    bus.thr_cfg = 8'd2;
    bus.step    = 8'd2;
    bus.stop    = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_idle_ignored", bus.busy, 0);
    start_pulse();
    chk("t1_en", bus.en, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_per", bus.per, 4);
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      m = i % 8;
      chk($sformatf("t1_cnt%0d", i), bus.cnt, (m <= 4) ? m : 8 - m);
      chk($sformatf("t1_tick%0d", i), bus.period_tick, (i == 9 || i == 17) ? 1 : 0);
      chk($sformatf("t1_thr%0d", i), bus.thr, (i >= 9 || !RAMP) ? 2 : 0);
      chk($sformatf("t1_rd%0d", i), bus.ramp_done, (i >= 9 || !RAMP) ? 1 : 0);
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    wait_idle();
    chk("t1_stop_cnt", bus.cnt, 0);
    chk("t1_stop_en", bus.en, 0);

    // per=10, thr=7, step=3: ramp 0,3,6,7,7
    bus.per_cfg = 8'd10;
    bus.thr_cfg = 8'd7;
    bus.step    = 8'd3;
    start_pulse();
    chk("t2_thr0", bus.thr, RAMP ? 0 : 7);
    chk("t2_per", bus.per, 10);
    for (int k = 0; k < 4; k++) begin
      wait_tick(cyc, pk);
      chk($sformatf("t2_thr%0d", k + 1), bus.thr, exp_thr2[k]);
      if (k > 0) chk($sformatf("t2_len%0d", k), cyc, 20);
    end
    chk("t2_rd", bus.ramp_done, 1);

    // per_cfg change mid-period takes effect at the next boundary
    bus.per_cfg = 8'd6;
    wait_tick(cyc, pk);
    chk("t3_old_peak", pk, 10);
    chk("t3_old_len", cyc, 20);
    chk("t3_per", bus.per, 6);
    wait_tick(cyc, pk);
    chk("t3_new_peak", pk, 6);
    chk("t3_new_len", cyc, 12);

    // stop at cnt=5 counting down: en drops exactly when cnt reaches 0
    wait_cnt(8'd5, 1'b0, "t4_cnt5_seen");
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    for (int v = 4; v >= 1; v--) begin
      if (v < 4) @(negedge clk);
      chk($sformatf("t4_cnt%0d", v), bus.cnt, v);
      chk($sformatf("t4_en%0d", v), bus.en, 1);
      chk($sformatf("t4_busy%0d", v), bus.busy, 1);
    end
    @(negedge clk);
    chk("t4_end_cnt", bus.cnt, 0);
    chk("t4_end_en", bus.en, 0);
    chk("t4_end_busy", bus.busy, 0);
    chk("t4_end_thr", bus.thr, 0);
    chk("t4_end_updn", bus.updn, 1);
    chk("t4_end_rd", bus.ramp_done, 0);
    repeat (3) @(negedge clk);
    chk("t4_hold_cnt", bus.cnt, 0);

    // per_cfg=0 rejected; then per=1 with start+stop together
    bus.per_cfg = 8'd0;
    start_pulse();
    chk("t5_cerr", bus.cfg_err, 1);
    chk("t5_en", bus.en, 0);
    chk("t5_busy", bus.busy, 0);
    @(negedge clk);
    chk("t5_cerr_pulse", bus.cfg_err, 0);
    bus.per_cfg = 8'd1;
    bus.thr_cfg = 8'd0;
    bus.stop    = 1'b1;
    start_pulse();
    bus.stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t5_cnt%0d", i), bus.cnt, i % 2);
      chk($sformatf("t5_tick%0d", i), bus.period_tick, (i >= 3 && (i % 2) == 1) ? 1 : 0);
      chk($sformatf("t5_busy%0d", i), bus.busy, 1);
    end

    // asynchronous reset at cnt=3
    bus.per_cfg = 8'd4;
    wait_cnt(8'd3, 1'b1, "t6_cnt3_seen");
    rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_post_en", bus.en, 0);
    chk("t6_post_cnt", bus.cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
